ps2_rx_fifo: RTL and testbench

- Parametrised PS/2 keyboard receiver, next generation of the single-register scancode peripheral.
- Recovers 11-bit PS/2 frames from kc/kd with a glitch filter and checks start, odd-parity and stop bits.
- Buffers accepted scancodes in a FIFO and exposes data, status, count and control registers on the memory-mapped slave.
- Raises a level interrupt to the CPU. Seven-segment display is not part of this block.

---
 rtl/ps2_rx_fifo.sv | 242 ++++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with scancode FIFO and register slave
//
// Purpose: filters the PS/2 kc/kd lines, deframes 11-bit frames (start, 8 data
// LSB first, odd parity, stop), queues good scancodes in a FIFO and exposes
// them through a small register slave with a level interrupt.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   irq         level interrupt, registered
//   s_cs_n      slave chip select, active low
//   s_address   register select (0 DATA, 1 STATUS/CONTROL, 2 COUNT, 3 zero)
//   s_read      read strobe; a read of DATA pops the FIFO head
//   s_readdata  read data, combinational from s_address and state
//   s_write     write strobe
//   s_writedata write data (CONTROL: bit0 irq_en, bit1 flush, bit2 clear errors)
//   kc, kd      PS/2 clock and data, asynchronous
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       irq,
  input  logic       s_cs_n,
  input  logic [1:0] s_address,
  input  logic       s_read,
  output logic [7:0] s_readdata,
  input  logic       s_write,
  input  logic [7:0] s_writedata,
  input  logic       kc,
  input  logic       kd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // ---------------------------------------------------------------------------
  // Input conditioning; index 0 is kc, index 1 is kd.
  // ---------------------------------------------------------------------------
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          kc_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      filt_q    <= 2'b11;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
      kc_prev_q <= 1'b1;
    end else begin
      sync1_q   <= {kd, kc};
      sync2_q   <= sync1_q;
      kc_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        // The counter tracks how many samples in a row disagree with the
        // filtered value; any agreeing sample restarts the run.
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic kc_fall;
  logic kd_f;
  assign kc_fall = kc_prev_q & ~filt_q[0];
  assign kd_f    = filt_q[1];

  // ---------------------------------------------------------------------------
  // Receive FSM with registered push / error-set pulses.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          push_q;
  logic [7:0]    push_data_q;
  logic          perr_set_q;
  logic          ferr_set_q;
  logic          par_ok;

  assign par_ok = ^{shift_q, par_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      perr_set_q  <= 1'b0;
      ferr_set_q  <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      perr_set_q <= 1'b0;
      ferr_set_q <= 1'b0;

      if (state_q == S_IDLE || kc_fall) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (kc_fall && !kd_f) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
          end
        end
        S_DATA: begin
          if (kc_fall) begin
            shift_q   <= {kd_f, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (kc_fall) begin
            par_q   <= kd_f;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (kc_fall) begin
            state_q     <= S_IDLE;
            push_q      <= par_ok & kd_f;
            push_data_q <= shift_q;
            perr_set_q  <= ~par_ok;
            ferr_set_q  <= ~kd_f;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // A stalled frame is abandoned; this overrides whatever the case chose.
      if (state_q != S_IDLE && !kc_fall && tmo_q == TW'(TIMEOUT - 1)) begin
        state_q    <= S_IDLE;
        ferr_set_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO, sticky flags, control and interrupt.
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q, perr_q, ferr_q, irq_en_q, irq_q;

  logic ctrl_wr, flush, clr_err, empty, full, pop, do_push, do_pop, ovf_set;

  assign ctrl_wr = ~s_cs_n & s_write & (s_address == 2'd1);
  assign flush   = ctrl_wr & s_writedata[1];
  assign clr_err = ctrl_wr & s_writedata[2];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = ~s_cs_n & s_read & (s_address == 2'd0) & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO fits.
  assign do_push = push_q & (~full | pop) & ~flush;
  assign do_pop  = pop & ~flush;
  assign ovf_set = push_q & full & ~pop & ~flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (do_push && !do_pop) begin
          count_q <= count_q + 1'b1;
        end else if (!do_push && do_pop) begin
          count_q <= count_q - 1'b1;
        end
      end
      // Set terms are OR-ed last so a new error survives a same-cycle clear.
      ovf_q  <= ovf_set    | (ovf_q  & ~clr_err);
      perr_q <= perr_set_q | (perr_q & ~clr_err);
      ferr_q <= ferr_set_q | (ferr_q & ~clr_err);
      if (ctrl_wr) begin
        irq_en_q <= s_writedata[0];
      end
      irq_q <= irq_en_q & (~empty | ovf_q | perr_q | ferr_q);
    end
  end

  assign irq = irq_q;

  logic [8:0] cnt_ext;
  assign cnt_ext = 9'(count_q);

  always_comb begin
    s_readdata = 8'h00;
    case (s_address)
      2'd0: s_readdata = empty ? 8'h00 : mem_q[rd_ptr_q];
      2'd1: s_readdata = {irq_en_q, 2'b00, ferr_q, perr_q, ovf_q, full, ~empty};
      2'd2: s_readdata = cnt_ext[8] ? 8'hFF : cnt_ext[7:0];
      default: s_readdata = 8'h00;
    endcase
  end

  logic unused_wdata;
  assign unused_wdata = ^s_writedata[7:3];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

  localparam int DEPTH = 16;
  localparam int FLEN  = 8;
  localparam int TMO   = 400;
  localparam int H     = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       irq;
  logic       s_cs_n;
  logic [1:0] s_address;
  logic       s_read;
  logic [7:0] s_readdata;
  logic       s_write;
  logic [7:0] s_writedata;
  logic       kc;
  logic       kd;

  int total = 0;
  int bad   = 0;

  logic [7:0] rd;

  ps2_rx_fifo #(
    .FIFO_DEPTH(DEPTH),
    .FILTER_LEN(FLEN),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq        (irq),
    .s_cs_n     (s_cs_n),
    .s_address  (s_address),
    .s_read     (s_read),
    .s_readdata (s_readdata),
    .s_write    (s_write),
    .s_writedata(s_writedata),
    .kc         (kc),
    .kd         (kd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reg_read(input logic [1:0] addr, output logic [7:0] data);
    @(negedge clk);
    s_cs_n    = 1'b0;
    s_read    = 1'b1;
    s_address = addr;
    #1 data = s_readdata;
    @(negedge clk);
    s_cs_n = 1'b1;
    s_read = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    s_cs_n      = 1'b0;
    s_write     = 1'b1;
    s_address   = addr;
    s_writedata = data;
    @(negedge clk);
    s_cs_n  = 1'b1;
    s_write = 1'b0;
  endtask

  // nbits < 11 sends a truncated frame; glitch adds a 2-cycle kc low pulse
  // in every high phase.
  task automatic send_frame(input logic [7:0] data, input logic par_flip,
                            input logic stop, input int nbits, input logic glitch);
    logic [10:0] fr;
    fr = {stop, (~^data) ^ par_flip, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kd = fr[i];
      repeat (H / 2) @(negedge clk);
      if (glitch) begin
        kc = 1'b0;
        repeat (2) @(negedge clk);
        kc = 1'b1;
      end
      repeat (H / 2) @(negedge clk);
      kc = 1'b0;
      repeat (H) @(negedge clk);
      kc = 1'b1;
    end
    kd = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    s_cs_n      = 1'b1;
    s_address   = 2'd0;
    s_read      = 1'b0;
    s_write     = 1'b0;
    s_writedata = 8'h00;
    kc          = 1'b1;
    kd          = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset state
    check("rst_irq", 16'(irq), 16'h0);
    reg_read(2'd1, rd); check("rst_status", 16'(rd), 16'h00);
    reg_read(2'd2, rd); check("rst_count", 16'(rd), 16'h00);
    reg_read(2'd0, rd); check("rst_data_empty", 16'(rd), 16'h00);
    reg_read(2'd3, rd); check("rst_addr3", 16'(rd), 16'h00);

    // Good frame 0x1C
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    check("f1_irq_disabled", 16'(irq), 16'h0);
    reg_read(2'd2, rd); check("f1_count", 16'(rd), 16'h01);
    reg_read(2'd1, rd); check("f1_status", 16'(rd), 16'h01);
    reg_read(2'd0, rd); check("f1_data", 16'(rd), 16'h1C);
    reg_read(2'd1, rd); check("f1_status_after", 16'(rd), 16'h00);

    // Interrupt
    reg_write(2'd1, 8'h01);
    reg_read(2'd1, rd); check("irq_en_status", 16'(rd), 16'h80);
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    check("irq_high", 16'(irq), 16'h1);
    reg_read(2'd0, rd); check("irq_data", 16'(rd), 16'hF0);
    check("irq_still_high", 16'(irq), 16'h1);
    @(negedge clk);
    check("irq_low", 16'(irq), 16'h0);
    reg_write(2'd1, 8'h00);

    // Parity error, stop error, both
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    reg_read(2'd1, rd); check("perr_status", 16'(rd), 16'h08);
    reg_read(2'd2, rd); check("perr_count", 16'(rd), 16'h00);
    reg_write(2'd1, 8'h04);
    reg_read(2'd1, rd); check("perr_cleared", 16'(rd), 16'h00);
    send_frame(8'h3C, 1'b0, 1'b0, 11, 1'b0);
    reg_read(2'd1, rd); check("ferr_status", 16'(rd), 16'h10);
    reg_write(2'd1, 8'h04);
    send_frame(8'h3C, 1'b1, 1'b0, 11, 1'b0);
    reg_read(2'd1, rd); check("both_err_status", 16'(rd), 16'h18);
    reg_write(2'd1, 8'h04);

    // Overflow
    for (int i = 1; i <= DEPTH + 1; i++) begin
      send_frame(8'(i), 1'b0, 1'b1, 11, 1'b0);
    end
    reg_read(2'd1, rd); check("ovf_status", 16'(rd), 16'h07);
    reg_read(2'd2, rd); check("ovf_count", 16'(rd), 16'd16);
    for (int i = 1; i <= DEPTH; i++) begin
      reg_read(2'd0, rd); check($sformatf("ovf_data_%0d", i), 16'(rd), 16'(i));
    end
    reg_read(2'd1, rd); check("ovf_drained", 16'(rd), 16'h04);
    reg_write(2'd1, 8'h04);
    reg_read(2'd1, rd); check("ovf_cleared", 16'(rd), 16'h00);

    // Flush
    send_frame(8'h22, 1'b0, 1'b1, 11, 1'b0);
    send_frame(8'h23, 1'b0, 1'b1, 11, 1'b0);
    reg_write(2'd1, 8'h02);
    reg_read(2'd2, rd); check("flush_count", 16'(rd), 16'h00);

    // Timeout
    send_frame(8'h0F, 1'b0, 1'b1, 4, 1'b0);
    repeat (TMO / 2) @(negedge clk);
    reg_read(2'd1, rd); check("tmo_not_yet", 16'(rd), 16'h00);
    repeat (TMO) @(negedge clk);
    reg_read(2'd1, rd); check("tmo_ferr", 16'(rd), 16'h10);
    send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
    reg_read(2'd2, rd); check("tmo_next_count", 16'(rd), 16'h01);
    reg_read(2'd0, rd); check("tmo_next_data", 16'(rd), 16'h5A);
    reg_write(2'd1, 8'h04);

    // Glitches on kc
    send_frame(8'hA5, 1'b0, 1'b1, 11, 1'b1);
    reg_read(2'd1, rd); check("glitch_status", 16'(rd), 16'h01);
    reg_read(2'd0, rd); check("glitch_data", 16'(rd), 16'hA5);

    // Reset mid-frame
    send_frame(8'h77, 1'b0, 1'b1, 11, 1'b0);
    send_frame(8'h12, 1'b1, 1'b1, 11, 1'b0);
    send_frame(8'h66, 1'b0, 1'b1, 5, 1'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_irq", 16'(irq), 16'h0);
    reg_read(2'd1, rd); check("midrst_status", 16'(rd), 16'h00);
    reg_read(2'd2, rd); check("midrst_count", 16'(rd), 16'h00);
    send_frame(8'h33, 1'b0, 1'b1, 11, 1'b0);
    reg_read(2'd0, rd); check("midrst_next_data", 16'(rd), 16'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
